// File: rtl/turn_scheduler.sv
// Turn scheduler for a keypad board game: players press a tile key, the compare
// datapath checks it against the next track tile, and a match advances the player.
module turn_scheduler_pos #(
    parameter int TRACK_LEN = 24,
    parameter int START     = 0
) (
    input  logic [5:0] steps,
    output logic [4:0] pos
);
    logic [6:0] sum;

    // steps never exceeds TRACK_LEN, so a single conditional subtract is a full mod
    assign sum = 7'(START) + {1'b0, steps};
    assign pos = (sum >= 7'(TRACK_LEN)) ? 5'(sum - 7'(TRACK_LEN)) : sum[4:0];
endmodule

module turn_scheduler #(
    parameter int NUM_PLAYERS = 4,
    parameter int TRACK_LEN   = 24,
    parameter int KEY_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] key,
    input  logic       match_done,
    input  logic       match,
    output logic       tile_req,
    output logic [3:0] tile_sel,
    output logic [4:0] tgt_pos,
    output logic [1:0] cur_player,
    output logic [4:0] cur_pos,
    output logic       move,
    output logic       win,
    output logic [1:0] winner,
    output logic [2:0] state
);
    localparam int SEG = TRACK_LEN / NUM_PLAYERS;
    localparam int TW  = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(KEY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_KEY = 3'd1,
        S_REQ      = 3'd2,
        S_WAIT_RES = 3'd3,
        S_MOVE     = 3'd4,
        S_NEXT     = 3'd5,
        S_WIN      = 3'd6
    } state_t;

    state_t                           st, st_nx;
    logic [3:0]                       key_q, key_prev;
    logic [TW-1:0]                    tmo;
    logic [NUM_PLAYERS-1:0][5:0]      steps;
    logic [NUM_PLAYERS-1:0][4:0]      pos_all;
    logic [1:0]                       player;
    logic                             accept;
    logic                             last_step;

    genvar i;
    generate
        for (i = 0; i < NUM_PLAYERS; i++) begin : g_pos
            turn_scheduler_pos #(.TRACK_LEN(TRACK_LEN), .START(i * SEG)) u_pos (
                .steps(steps[i]),
                .pos  (pos_all[i])
            );
        end
    endgenerate

    // key is registered once; a press counts only on the f->non-f transition
    assign accept     = (key_q != 4'hf) && (key_prev == 4'hf);
    assign last_step  = (steps[player] == 6'(TRACK_LEN - 1));
    assign cur_player = player;
    assign cur_pos    = pos_all[player];
    assign tgt_pos    = (cur_pos == 5'(TRACK_LEN - 1)) ? 5'd0 : cur_pos + 5'd1;
    assign state      = st;

    always_comb begin
        st_nx = st;
        case (st)
            S_IDLE, S_WIN: if (start) st_nx = S_WAIT_KEY;
            S_WAIT_KEY: begin
                if (accept)               st_nx = S_REQ;
                else if (tmo == TMO_LAST) st_nx = S_NEXT;
            end
            S_REQ:      st_nx = S_WAIT_RES;
            S_WAIT_RES: if (match_done) st_nx = match ? S_MOVE : S_NEXT;
            S_MOVE:     st_nx = last_step ? S_WIN : S_WAIT_KEY;
            S_NEXT:     st_nx = S_WAIT_KEY;
            default:    st_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            player   <= 2'd0;
            steps    <= '0;
            tmo      <= '0;
            tile_sel <= 4'hf;
            tile_req <= 1'b0;
            move     <= 1'b0;
            win      <= 1'b0;
            winner   <= 2'd0;
            key_q    <= 4'hf;
            key_prev <= 4'hf;
        end else begin
            st       <= st_nx;
            key_q    <= key;
            key_prev <= key_q;
            // pulses are decoded from the next state so they line up with it
            tile_req <= (st_nx == S_REQ);
            move     <= (st_nx == S_MOVE);
            win      <= (st_nx == S_WIN);
            case (st)
                S_IDLE, S_WIN: begin
                    if (start) begin
                        steps  <= '0;
                        player <= 2'd0;
                        tmo    <= '0;
                    end
                end
                S_WAIT_KEY: begin
                    if (accept) begin
                        tile_sel <= key_q;
                        tmo      <= '0;
                    end else if (tmo != TMO_LAST) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_MOVE: begin
                    steps[player] <= steps[player] + 6'd1;
                    tmo           <= '0;
                    if (last_step) winner <= player;
                end
                S_NEXT: begin
                    player <= (player == 2'(NUM_PLAYERS - 1)) ? 2'd0 : player + 2'd1;
                    tmo    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: cycle vector table, directed corner sequences and a
// random game checked against a turn-level model of the rules.
module tb_turn_scheduler;
    localparam int NP = 4;
    localparam int TL = 24;
    localparam int KT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0, start = 1'b0, match_done = 1'b0, match = 1'b0;
    logic [3:0] key = 4'hf;
    logic       tile_req, move, win;
    logic [3:0] tile_sel;
    logic [4:0] tgt_pos, cur_pos;
    logic [1:0] cur_player, winner;
    logic [2:0] state;

    int checks = 0, passed = 0;

    turn_scheduler #(.NUM_PLAYERS(NP), .TRACK_LEN(TL), .KEY_TIMEOUT(KT)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .match_done(match_done),
        .match(match), .tile_req(tile_req), .tile_sel(tile_sel), .tgt_pos(tgt_pos),
        .cur_player(cur_player), .cur_pos(cur_pos), .move(move), .win(win),
        .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start;
        logic [3:0] key;
        logic       md, m;
        int         st, tr, mv, pl, pos, sel;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t v(input logic r, input logic s, input logic [3:0] k,
                               input logic md, input logic m, input int st, input int tr,
                               input int mv, input int pl, input int pos, input int sel);
        vec_t x;
        x.rst = r; x.start = s; x.key = k; x.md = md; x.m = m;
        x.st = st; x.tr = tr; x.mv = mv; x.pl = pl; x.pos = pos; x.sel = sel;
        return x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic do_reset;
        rst = 1'b1; tick; rst = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1; tick; start = 1'b0;
    endtask

    // one keyed turn starting from the first cycle of WAIT_KEY; ends back in a stable state
    task automatic do_turn(input logic [3:0] k, input logic m, input int dly, output logic mv);
        key = k; tick;
        key = 4'hf; tick;
        chk("turn_tile_req", int'(tile_req), 1);
        chk("turn_tile_sel", int'(tile_sel), int'(k));
        tick;
        chk("turn_req_drop", int'(tile_req), 0);
        repeat (dly) tick;
        match_done = 1'b1; match = m; tick;
        mv = move;
        match_done = 1'b0; match = 1'b0; tick;
    endtask

    function automatic int exp_pos(input int p, input int s);
        return (p * (TL / NP) + s) % TL;
    endfunction

    int   msteps[NP];
    int   mp, r, d;
    logic m, mv;
    logic [3:0] k;

    initial begin
        // ---- cycle vector table: basic compare flow, player handoff, reset mid-compare
        tbl[0]  = v(1, 0, 4'hf, 0, 0, 0, 0, 0, 0, 0, 15);
        tbl[1]  = v(0, 0, 4'hf, 1, 1, 0, 0, 0, 0, 0, 15);
        tbl[2]  = v(0, 1, 4'hf, 0, 0, 1, 0, 0, 0, 0, 15);
        tbl[3]  = v(0, 0, 4'h3, 0, 0, 1, 0, 0, 0, 0, 15);
        tbl[4]  = v(0, 0, 4'hf, 0, 0, 2, 1, 0, 0, 0, 3);
        tbl[5]  = v(0, 0, 4'hf, 0, 0, 3, 0, 0, 0, 0, 3);
        tbl[6]  = v(0, 1, 4'hf, 0, 0, 3, 0, 0, 0, 0, 3);
        tbl[7]  = v(0, 0, 4'hf, 1, 1, 4, 0, 1, 0, 0, 3);
        tbl[8]  = v(0, 0, 4'hf, 0, 0, 1, 0, 0, 0, 1, 3);
        tbl[9]  = v(0, 0, 4'h3, 0, 0, 1, 0, 0, 0, 1, 3);
        tbl[10] = v(0, 0, 4'hf, 0, 0, 2, 1, 0, 0, 1, 3);
        tbl[11] = v(0, 0, 4'hf, 0, 0, 3, 0, 0, 0, 1, 3);
        tbl[12] = v(0, 0, 4'hf, 1, 0, 5, 0, 0, 0, 1, 3);
        tbl[13] = v(0, 0, 4'hf, 0, 0, 1, 0, 0, 1, 6, 3);
        tbl[14] = v(0, 0, 4'h7, 0, 0, 1, 0, 0, 1, 6, 3);
        tbl[15] = v(0, 0, 4'hf, 0, 0, 2, 1, 0, 1, 6, 7);
        tbl[16] = v(0, 0, 4'hf, 0, 0, 3, 0, 0, 1, 6, 7);
        tbl[17] = v(1, 0, 4'hf, 0, 0, 0, 0, 0, 0, 0, 15);
        tbl[18] = v(0, 0, 4'hf, 1, 1, 0, 0, 0, 0, 0, 15);
        tbl[19] = v(0, 0, 4'hf, 0, 0, 0, 0, 0, 0, 0, 15);

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; key = tbl[i].key;
            match_done = tbl[i].md; match = tbl[i].m;
            tick;
            chk($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("vec%0d_tile_req", i), int'(tile_req), tbl[i].tr);
            chk($sformatf("vec%0d_move", i), int'(move), tbl[i].mv);
            chk($sformatf("vec%0d_player", i), int'(cur_player), tbl[i].pl);
            chk($sformatf("vec%0d_pos", i), int'(cur_pos), tbl[i].pos);
            chk($sformatf("vec%0d_sel", i), int'(tile_sel), tbl[i].sel);
        end
        rst = 0; start = 0; key = 4'hf; match_done = 0; match = 0;
        chk("reset_win", int'(win), 0);
        chk("reset_winner", int'(winner), 0);

        // ---- key held across two turns is not re-accepted; turn times out
        do_reset; do_start;
        key = 4'h5; tick; tick;
        chk("held_first_req", int'(tile_req), 1);
        tick;
        match_done = 1'b1; match = 1'b0; tick;
        match_done = 1'b0; tick;
        chk("held_p1", int'(cur_player), 1);
        repeat (KT - 1) tick;
        chk("held_still_wait", int'(state), 1);
        tick;
        chk("held_timeout_next", int'(state), 5);
        tick;
        chk("held_p2", int'(cur_player), 2);
        chk("held_p2_pos", int'(cur_pos), 12);
        key = 4'hf; tick;

        // ---- key accepted on the last timeout cycle wins; one cycle later loses
        do_reset; do_start;
        repeat (KT - 2) tick;
        key = 4'h5; tick;
        chk("edge_last_wait", int'(state), 1);
        key = 4'hf; tick;
        chk("edge_req", int'(state), 2);
        chk("edge_player", int'(cur_player), 0);
        tick;
        match_done = 1'b1; match = 1'b0; tick;
        match_done = 1'b0; tick;
        chk("edge_p1", int'(cur_player), 1);
        repeat (KT - 1) tick;
        key = 4'h9; tick;
        chk("late_key_next", int'(state), 5);
        key = 4'hf; tick;
        chk("late_key_p2", int'(cur_player), 2);

        // ---- player 3 walks the full track and wins; restart from WIN
        do_reset; do_start;
        for (int i = 0; i < 3; i++) do_turn(4'h1, 1'b0, 0, mv);
        chk("win_p3", int'(cur_player), 3);
        chk("win_p3_start", int'(cur_pos), 18);
        for (int i = 1; i <= TL; i++) begin
            do_turn(4'(i % 15), 1'b1, i % 3, mv);
            chk("win_walk_move", int'(mv), 1);
            if (i < TL) begin
                chk("win_walk_state", int'(state), 1);
                chk("win_walk_pos", int'(cur_pos), exp_pos(3, i));
            end
        end
        chk("win_state", int'(state), 6);
        chk("win_flag", int'(win), 1);
        chk("win_winner", int'(winner), 3);
        key = 4'h2; tick; key = 4'hf; tick;
        chk("win_key_ignored", int'(state), 6);
        do_start;
        chk("restart_state", int'(state), 1);
        chk("restart_win", int'(win), 0);
        chk("restart_pos0", int'(cur_pos), 0);
        for (int p = 1; p < NP; p++) begin
            do_turn(4'h4, 1'b0, 1, mv);
            chk("restart_player", int'(cur_player), p);
            chk("restart_pos", int'(cur_pos), exp_pos(p, 0));
        end

        // ---- random game against the turn-level model
        do_reset; do_start;
        mp = 0;
        for (int p = 0; p < NP; p++) msteps[p] = 0;
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                repeat (KT + 1) tick;
                mp = (mp + 1) % NP;
            end else begin
                if (r < 20) begin
                    match_done = 1'b1; match = 1'b1; tick;
                    match_done = 1'b0; match = 1'b0;
                    chk("rnd_stray_md", int'(state), 1);
                end
                k = 4'($urandom_range(0, 14));
                m = ($urandom_range(0, 9) < 7);
                d = $urandom_range(0, 3);
                do_turn(k, m, d, mv);
                chk("rnd_move", int'(mv), int'(m));
                if (m) begin
                    msteps[mp]++;
                    if (msteps[mp] == TL) begin
                        chk("rnd_win_state", int'(state), 6);
                        chk("rnd_winner", int'(winner), mp);
                        do_start;
                        mp = 0;
                        for (int p = 0; p < NP; p++) msteps[p] = 0;
                    end
                end else begin
                    mp = (mp + 1) % NP;
                end
            end
            chk("rnd_state", int'(state), 1);
            chk("rnd_player", int'(cur_player), mp);
            chk("rnd_pos", int'(cur_pos), exp_pos(mp, msteps[mp]));
            chk("rnd_tgt", int'(tgt_pos), (exp_pos(mp, msteps[mp]) + 1) % TL);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
